// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg
// Shared definitions for the HI/LO divide controller: request op codes, the
// controller FSM state encoding, the iteration count of the bit-serial divider
// and a conditional two's-complement helper used for sign handling.
// -----------------------------------------------------------------------------
package hilo_pkg;

  // Request op codes carried on req_op
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  // One quotient bit per RUN cycle
  localparam int         DIV_ITERS = 32;
  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Two's-complement negate when requested, pass-through otherwise
  function automatic logic [31:0] neg_if(input logic [31:0] value, input logic negate);
    logic [31:0] result;
    if (negate) begin
      result = 32'd0 - value;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_div_core.sv
// -----------------------------------------------------------------------------
// div_core
// Unsigned restoring shift/subtract divider, one quotient bit per step.
// The quotient register starts out holding the dividend; each step shifts its
// top bit into the partial remainder and shifts the new quotient bit in at the
// bottom. A zero divisor always "fits", giving an all-ones quotient and the
// dividend as remainder.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   load               capture dividend/divisor, clear remainder and count
//   step               perform one iteration
//   dividend, divisor  unsigned operands (sampled on load)
//   quotient,remainder current results (final after 32 steps)
//   count              iterations completed since load (wraps to 0 after 32)
// -----------------------------------------------------------------------------
module div_core
  import hilo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [4:0]  count
);

  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dsr_r;
  logic [4:0]  count_r;

  logic [32:0] partial_s;
  logic [31:0] diff_s;
  logic        fits_s;

  // Trial subtraction for the current iteration
  always_comb begin
    partial_s = {rem_r, quo_r[31]};
    // When the divisor fits the difference is below the divisor, so 32 bits suffice
    diff_s    = partial_s[31:0] - dsr_r;
    fits_s    = (partial_s >= {1'b0, dsr_r});
  end

  // Datapath and iteration counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      quo_r   <= 32'd0;
      rem_r   <= 32'd0;
      dsr_r   <= 32'd0;
      count_r <= 5'd0;
    end else if (load) begin
      quo_r   <= dividend;
      rem_r   <= 32'd0;
      dsr_r   <= divisor;
      count_r <= 5'd0;
    end else if (step) begin
      if (fits_s) begin
        rem_r <= diff_s;
      end else begin
        rem_r <= partial_s[31:0];
      end
      quo_r   <= {quo_r[30:0], fits_s};
      count_r <= count_r + 5'd1;
    end else begin
      quo_r   <= quo_r;
      rem_r   <= rem_r;
      dsr_r   <= dsr_r;
      count_r <= count_r;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign count     = count_r;

endmodule

// File: rtl/hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_div_ctrl
// HI/LO register owner with a multi-cycle signed/unsigned divider.
// DIV/DIVU run IDLE -> LOAD -> RUN (32 cycles) -> FIN -> IDLE; hi/lo are written
// on the edge leaving FIN and done pulses for the following cycle. MTHI/MTLO
// write hi/lo directly when accepted in IDLE. All sign handling lives here;
// div_core only ever sees magnitudes.
//
// Optional feature: define HILO_DIV_ZERO_TRAP_EN to add the div_zero output.
// A zero divisor then returns LOAD -> IDLE with hi/lo untouched and pulses
// done and div_zero together.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req_valid, req_op   request and op code (DIV, DIVU, MTHI, MTLO)
//   rs_data, rt_data    dividend / move source, divisor
//   req_ready           high when a request would be accepted this cycle
//   stall               divide in flight
//   hi, lo              remainder / quotient registers
//   done                one-cycle pulse when a divide retires
//   div_zero            divide-by-zero pulse (HILO_DIV_ZERO_TRAP_EN only)
// -----------------------------------------------------------------------------
module hilo_div_ctrl
  import hilo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        req_ready,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
`ifdef HILO_DIV_ZERO_TRAP_EN
  ,
  output logic        div_zero
`endif
);

  state_t      state_r;
  state_t      state_s;

  logic        signed_r;
  logic [31:0] rs_r;
  logic [31:0] rt_r;
  logic        q_neg_r;
  logic        r_neg_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;

  logic        accept_s;
  logic        is_div_s;
  logic        rs_neg_s;
  logic        rt_neg_s;
  logic [31:0] rs_mag_s;
  logic [31:0] rt_mag_s;
  logic        core_load_s;
  logic        core_step_s;
  logic        fin_s;
  logic        trap_s;

  logic [31:0] core_quo_s;
  logic [31:0] core_rem_s;
  logic [4:0]  core_count_s;

  // Handshake and operand magnitude decode
  always_comb begin
    req_ready = (state_r == ST_IDLE) && !reset;
    accept_s  = req_valid && req_ready;
    is_div_s  = (req_op == OP_DIV) || (req_op == OP_DIVU);
    // Sign flags only matter for DIV; DIVU operands go through raw
    rs_neg_s  = signed_r && rs_r[31];
    rt_neg_s  = signed_r && rt_r[31];
    rs_mag_s  = neg_if(rs_r, rs_neg_s);
    rt_mag_s  = neg_if(rt_r, rt_neg_s);
  end

  // Next-state and datapath control
  always_comb begin
    state_s     = state_r;
    core_load_s = 1'b0;
    core_step_s = 1'b0;
    fin_s       = 1'b0;
    trap_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_div_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
`ifdef HILO_DIV_ZERO_TRAP_EN
        if (rt_r == 32'd0) begin
          trap_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          core_load_s = 1'b1;
          state_s     = ST_RUN;
        end
`else
        core_load_s = 1'b1;
        state_s     = ST_RUN;
`endif
      end
      ST_RUN: begin
        core_step_s = 1'b1;
        // The counter reads LAST_ITER while the 32nd step is being taken
        if (core_count_s == LAST_ITER) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FIN: begin
        fin_s   = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Raw operand capture on the accepting edge; the requester may drop them afterwards
  always_ff @(posedge clock) begin
    if (reset) begin
      rs_r     <= 32'd0;
      rt_r     <= 32'd0;
      signed_r <= 1'b0;
    end else if (accept_s && is_div_s) begin
      rs_r     <= rs_data;
      rt_r     <= rt_data;
      signed_r <= (req_op == OP_DIV);
    end else begin
      rs_r     <= rs_r;
      rt_r     <= rt_r;
      signed_r <= signed_r;
    end
  end

  // Result sign flags, latched as the core is loaded
  always_ff @(posedge clock) begin
    if (reset) begin
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (core_load_s) begin
      q_neg_r <= rs_neg_s ^ rt_neg_s;
      r_neg_r <= rs_neg_s;
    end else begin
      q_neg_r <= q_neg_r;
      r_neg_r <= r_neg_r;
    end
  end

  // HI/LO registers: divide retire or direct moves, otherwise hold
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (fin_s) begin
      lo_r <= neg_if(core_quo_s, q_neg_r);
      hi_r <= neg_if(core_rem_s, r_neg_r);
    end else if (accept_s && (req_op == OP_MTHI)) begin
      hi_r <= rs_data;
      lo_r <= lo_r;
    end else if (accept_s && (req_op == OP_MTLO)) begin
      hi_r <= hi_r;
      lo_r <= rs_data;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Retire pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      done_r <= 1'b0;
    end else begin
      done_r <= fin_s || trap_s;
    end
  end

`ifdef HILO_DIV_ZERO_TRAP_EN
  logic div_zero_r;

  // Divide-by-zero pulse, coincident with done
  always_ff @(posedge clock) begin
    if (reset) begin
      div_zero_r <= 1'b0;
    end else begin
      div_zero_r <= trap_s;
    end
  end

  assign div_zero = div_zero_r;
`endif

  div_core u_div_core (
    .clock     (clock),
    .reset     (reset),
    .load      (core_load_s),
    .step      (core_step_s),
    .dividend  (rs_mag_s),
    .divisor   (rt_mag_s),
    .quotient  (core_quo_s),
    .remainder (core_rem_s),
    .count     (core_count_s)
  );

  assign stall = (state_r != ST_IDLE);
  assign hi    = hi_r;
  assign lo    = lo_r;
  assign done  = done_r;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_ctrl
// Scoreboard bench: each accepted divide pushes its expected hi/lo and retire
// cycle; a negedge monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_hilo_div_ctrl;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        req_ready;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
`ifdef HILO_DIV_ZERO_TRAP_EN
  logic        div_zero;
`endif

  hilo_div_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .req_ready (req_ready),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .done      (done)
`ifdef HILO_DIV_ZERO_TRAP_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    logic        trap;
  } entry_t;

  entry_t      sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference divide written from the architectural definition
  function automatic res_t model_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [31:0] ma;
    if (op == 2'b01) begin
      if (b == 32'd0) begin
        r.lo = 32'hFFFF_FFFF;
        r.hi = a;
      end else begin
        r.lo = a / b;
        r.hi = a % b;
      end
    end else if (b == 32'd0) begin
      ma   = a[31] ? (32'd0 - a) : a;
      r.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
      r.hi = a[31] ? (32'd0 - ma) : ma;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.lo = 32'h8000_0000;
      r.hi = 32'd0;
    end else begin
      r.lo = $signed(a) / $signed(b);
      r.hi = $signed(a) % $signed(b);
    end
    return r;
  endfunction

  // Scoreboard monitor: every done must match the oldest outstanding divide
  always @(negedge clock) begin
    entry_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("lo", lo, e.lo);
        check_eq("hi", hi, e.hi);
        check_eq("latency", 32'(cyc), 32'(e.due));
        check_eq("ready_with_done", 32'(req_ready), 32'd1);
`ifdef HILO_DIV_ZERO_TRAP_EN
        check_eq("div_zero", 32'(div_zero), 32'(e.trap));
`endif
      end
    end
  end

  // Drive a request until accepted; divides push their expected result
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input res_t exp_r, output logic done_at_acc);
    int     budget;
    entry_t e;
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = op;
    rs_data   = a;
    rt_data   = b;
    budget    = 0;
    while (!req_ready && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (!req_ready) check_eq("accept_timeout", 32'(req_ready), 32'd1);
    done_at_acc = done;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    if (op[1] == 1'b0) begin
      e.trap = 1'b0;
`ifdef HILO_DIV_ZERO_TRAP_EN
      e.trap = (b == 32'd0);
`endif
      if (e.trap) begin
        e.hi  = mdl_hi;
        e.lo  = mdl_lo;
        e.due = cyc + 1;
      end else begin
        e.hi  = exp_r.hi;
        e.lo  = exp_r.lo;
        e.due = cyc + 34;
      end
      mdl_hi = e.hi;
      mdl_lo = e.lo;
      sb.push_back(e);
    end else if (op == 2'b10) begin
      mdl_hi = a;
    end else begin
      mdl_lo = a;
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || stall) && budget < 80) begin
      @(negedge clock);
      budget++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        dn;
    res_t        r;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    rs_data   = 32'd0;
    rt_data   = 32'd0;
    repeat (2) @(posedge clock);
    // A move request held during reset must be ignored
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = 2'b10;
    rs_data   = 32'hDEAD_BEEF;
    @(negedge clock);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    check_eq("ready_after_rst", 32'(req_ready), 32'd1);
    check_eq("hi_after_rst", hi, 32'd0);

    // 7 / -2
    r.hi = 32'h0000_0001; r.lo = 32'hFFFF_FFFD;
    issue(2'b00, 32'd7, 32'hFFFF_FFFE, r, dn);
    @(negedge clock);
    check_eq("stall_busy", 32'(stall), 32'd1);
    check_eq("ready_busy", 32'(req_ready), 32'd0);
    wait_drain();

    // -7 / 2
    r.hi = 32'hFFFF_FFFF; r.lo = 32'hFFFF_FFFD;
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, r, dn);
    wait_drain();

    // DIVU 0xFFFFFFFF / 16
    r.hi = 32'h0000_000F; r.lo = 32'h0FFF_FFFF;
    issue(2'b01, 32'hFFFF_FFFF, 32'h10, r, dn);
    wait_drain();

    // MTLO leaves hi alone
    issue(2'b11, 32'h0000_CAFE, 32'd0, r, dn);
    check_eq("mtlo_lo", lo, 32'h0000_CAFE);
    check_eq("mtlo_hi", hi, 32'h0000_000F);

    // Overflow wrap, with MTHI held off until the done cycle
    r.hi = 32'd0; r.lo = 32'h8000_0000;
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, dn);
    repeat (10) @(negedge clock);
    req_valid = 1'b1;
    req_op    = 2'b10;
    rs_data   = 32'h0000_1234;
    #1;
    check_eq("mthi_ready_run", 32'(req_ready), 32'd0);
    issue(2'b10, 32'h0000_1234, 32'd0, r, dn);
    check_eq("mthi_at_done", 32'(dn), 32'd1);
    check_eq("mthi_hi", hi, 32'h0000_1234);
    check_eq("mthi_lo", lo, 32'h8000_0000);
    wait_drain();

    // Divide by zero, unsigned and signed
    issue(2'b01, 32'd5, 32'd0, model_div(2'b01, 32'd5, 32'd0), dn);
    wait_drain();
    issue(2'b00, 32'hFFFF_FFFB, 32'd0, model_div(2'b00, 32'hFFFF_FFFB, 32'd0), dn);
    wait_drain();

    // Mixed random divides
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 1));
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) b = 32'hFFFF_FFFF;
      issue(op, a, b, model_div(op, a, b), dn);
      wait_drain();
    end

    // Reset in the middle of RUN discards the divide
    a = 32'h0001_0000;
    issue(2'b00, a, 32'd3, model_div(2'b00, a, 32'd3), dn);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
    @(posedge clock);
    #1;
    check_eq("midrst_stall", 32'(stall), 32'd0);
    check_eq("midrst_hi", hi, 32'd0);
    check_eq("midrst_lo", lo, 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check_eq("midrst_idle", 32'(stall), 32'd0);

    // Recovery divide after reset
    issue(2'b01, 32'd100, 32'd7, model_div(2'b01, 32'd100, 32'd7), dn);
    wait_drain();
    repeat (3) @(negedge clock);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
